adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
Amplitude envelope stage that sits between the waveform-select mux and the I2S serializer. It consumes the selected 24-bit signed sample and a note gate, and produces the gain-scaled sample for I2S. It runs an Attack/Decay/Sustain/Release FSM with a 16-bit level that is stepped on an internal sample-rate tick. Step and sustain settings come from the top level (switches/NIOS PIO).

Parameters:
SAMPLE_W, 24, sample width (two's complement)
LEVEL_W, 16, envelope level width (unsigned; full scale 0xFFFF)
TICK_DIV, 1042, clk cycles per envelope tick (about 48 kHz at 50 MHz); minimum 2

Ports:
clk  in  1  system clock (MAX10_CLK1_50)
reset  in  1  asynchronous, active-high reset
gate  in  1  note on (1) / note off (0); synchronous to clk unless ADSR_GATE_SYNC_EN
attack_step  in  LEVEL_W  level increment per tick in ATTACK
decay_step  in  LEVEL_W  level decrement per tick in DECAY
sustain_level  in  LEVEL_W  sustain target
release_step  in  LEVEL_W  level decrement per tick in RELEASE
sample_in  in  SAMPLE_W  signed raw waveform
sample_out  out  SAMPLE_W  signed enveloped sample (registered)
level  out  LEVEL_W  current envelope level
state  out  3  current FSM state (package encoding)
active  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. On reset: sample_out=0, level=0, state=IDLE, active=0, tick counter=0, gate history=0.
- Tick: counter counts 0..TICK_DIV-1 and wraps. tick is high for one cycle when the counter equals TICK_DIV-1.
- Gate edges are detected against a 1-cycle delayed gate and act on the next clk edge, independent of tick.
  - Rising edge, from any state: go to ATTACK. level is kept (retrigger from the current level, no reset to zero).
  - Falling edge, from ATTACK, DECAY or SUSTAIN: go to RELEASE. level is kept.
  - A gate edge and a tick in the same cycle: the edge wins and no level step is applied that cycle.
- Level update, only on tick with no gate edge:
  - IDLE: level=0.
  - ATTACK: level=min(level+attack_step, 0xFFFF), computed in LEVEL_W+1 bits. When the result is 0xFFFF, go to DECAY. attack_step=0 means instant: level=0xFFFF and go to DECAY.
  - DECAY: level=max(level-decay_step, sustain_level), with no underflow. When the result equals sustain_level, go to SUSTAIN. decay_step=0 means instant.
  - SUSTAIN: level=sustain_level, tracking live changes on each tick.
  - RELEASE: level=max(level-release_step, 0). When the result is 0, go to IDLE. release_step=0 means instant.
  - If sustain_level > level on DECAY entry, level is set to sustain_level and the FSM goes to SUSTAIN on the first tick.
- Scaling: sample_out(n+1) = (sample_in(n) * {1'b0,level(n)}) >>> LEVEL_W.
  - Signed 24x17 multiply, arithmetic shift with floor rounding, then truncate to SAMPLE_W. Overflow is impossible.
  - Latency is 1 clk.
- reset asserted mid-operation forces the reset values immediately. The FSM resumes in IDLE, and the next gate rise is needed to start a new envelope.

Optional Feature:
ADSR_GATE_SYNC_EN
- Defined: gate passes through a 2-flop synchronizer (reset to 0) before edge detection. Gate-to-state latency is 3 clk, so gate may be driven directly from KEY or switches.
- Undefined: gate is used directly. Gate-to-state latency is 1 clk.

Decomposition:
- Package adsr_pkg:
  - typedef enum logic [2:0] adsr_state_t {IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4}.
  - localparams for LEVEL_W default and LEVEL_MAX=16'hFFFF.
- Sub-module adsr_tick_gen: parameter TICK_DIV; ports clk, reset, tick. It is reusable by the other wave generators.

Test Plan:
- Reset: assert reset with gate=1 mid-attack -> sample_out=0, level=0, state=IDLE, active=0 asynchronously; after release, no activity until the next gate rise.
- Attack: TICK_DIV=4, attack_step=0x4000, gate 0->1 -> state=ATTACK after 1 clk; level is 0x4000, 0x8000, 0xC000 on the first three ticks, then 0xFFFF (saturated) with state=DECAY on the 4th.
- Decay/sustain: decay_step=0x1000, sustain_level=0x8000, from 0xFFFF -> 0xEFFF ... 0x8FFF, then 0x8000 and SUSTAIN on tick 8; changing sustain_level to 0x6000 -> level=0x6000 on the next tick.
- Release and zero step: gate 1->0 in SUSTAIN -> RELEASE next clk; release_step=0 -> level=0, state=IDLE, active=0 on the next tick. Retrigger at level 0x3000 in RELEASE -> ATTACK starting from 0x3000.
- Scaling:
  - level=0xFFFF: sample_in 0x7FFFFF -> sample_out 0x7FFF7F; 0x800000 -> 0x800080.
  - level=0x8000: sample_in 0x400000 -> 0x200000.
  - level=0: output is 0.
  - Each result appears 1 clk after sample_in.
- Simultaneous edge and tick: gate rise in the same cycle as a tick in DECAY -> state=ATTACK, level unchanged that cycle. With ADSR_GATE_SYNC_EN, the state change occurs 3 clk after the gate change.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared state encoding and default widths for the ADSR envelope and its tick generator.
package adsr_pkg;

  localparam int unsigned SAMPLE_W_DEF = 24;
  localparam int unsigned LEVEL_W_DEF  = 16;
  localparam int unsigned TICK_DIV_DEF = 1042;
  localparam logic [15:0] LEVEL_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

endpackage

// File: rtl/adsr_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks (TICK_DIV >= 2).
module adsr_tick_gen #(
  parameter int unsigned TICK_DIV = 1042
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered one count early so it is high exactly while r_cnt == TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_W'(TICK_DIV - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven level FSM stepped on a sample tick, applied to the
// sample with a 1-clk multiply. Define ADSR_GATE_SYNC_EN to add a 2-flop gate synchronizer.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned LEVEL_W  = LEVEL_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gate,
  input  logic [LEVEL_W-1:0]  attack_step,
  input  logic [LEVEL_W-1:0]  decay_step,
  input  logic [LEVEL_W-1:0]  sustain_level,
  input  logic [LEVEL_W-1:0]  release_step,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic [LEVEL_W-1:0]  level,
  output logic [2:0]          state,
  output logic                active
);

  localparam int unsigned        PROD_W = SAMPLE_W + LEVEL_W + 1;
  localparam logic [LEVEL_W-1:0] L_FULL = '1;

  logic w_tick;

  adsr_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  logic w_gate;

`ifdef ADSR_GATE_SYNC_EN
  logic r_gate_s1;
  logic r_gate_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate_s1 <= 1'b0;
      r_gate_s2 <= 1'b0;
    end else begin
      r_gate_s1 <= gate;
      r_gate_s2 <= r_gate_s1;
    end
  end

  assign w_gate = r_gate_s2;
`else
  assign w_gate = gate;
`endif

  logic               r_gate_d;
  logic               w_rise;
  logic               w_fall;
  adsr_state_t        r_state;
  adsr_state_t        w_state_nxt;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic               r_active;
  logic [LEVEL_W:0]   w_att_sum;
  logic [LEVEL_W-1:0] w_dec_room;

  assign w_rise     = w_gate & ~r_gate_d;
  assign w_fall     = ~w_gate & r_gate_d;
  assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_step};
  assign w_dec_room = r_level - sustain_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_level  <= '0;
      r_active <= 1'b0;
      r_gate_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_active <= (w_state_nxt != IDLE);
      r_gate_d <= w_gate;
    end
  end

  // Gate edges take priority over the tick; a step of zero completes a phase at once.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_rise) begin
      w_state_nxt = ATTACK;
    end else if (w_fall) begin
      if (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN) begin
        w_state_nxt = RELEASE;
      end
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_level_nxt = '0;
        end
        ATTACK: begin
          if (attack_step == '0 || w_att_sum >= {1'b0, L_FULL}) begin
            w_level_nxt = L_FULL;
            w_state_nxt = DECAY;
          end else begin
            w_level_nxt = w_att_sum[LEVEL_W-1:0];
          end
        end
        DECAY: begin
          if (decay_step == '0 || r_level <= sustain_level || decay_step >= w_dec_room) begin
            w_level_nxt = sustain_level;
            w_state_nxt = SUSTAIN;
          end else begin
            w_level_nxt = r_level - decay_step;
          end
        end
        SUSTAIN: begin
          w_level_nxt = sustain_level;
        end
        RELEASE: begin
          if (release_step == '0 || release_step >= r_level) begin
            w_level_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_level_nxt = r_level - release_step;
          end
        end
        default: begin
          w_level_nxt = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  logic signed [PROD_W-1:0] w_smp_ext;
  logic signed [PROD_W-1:0] w_lvl_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic [SAMPLE_W-1:0]      r_sample_out;

  // Level is treated as an unsigned fraction of full scale; the shift floors toward -inf.
  assign w_smp_ext = PROD_W'($signed(sample_in));
  assign w_lvl_ext = PROD_W'({1'b0, r_level});
  assign w_prod    = w_smp_ext * w_lvl_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_out <= '0;
    end else begin
      r_sample_out <= SAMPLE_W'(w_prod >>> LEVEL_W);
    end
  end

  assign sample_out = r_sample_out;
  assign level      = r_level;
  assign state      = r_state;
  assign active     = r_active;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: scaling vector table, directed envelope sequences and
// randomized stimulus compared every cycle against a behavioural envelope model.
module tb_adsr_envelope;

  localparam int TICK_DIV  = 4;
  localparam int S_IDLE    = 0;
  localparam int S_ATTACK  = 1;
  localparam int S_DECAY   = 2;
  localparam int S_SUSTAIN = 3;
  localparam int S_RELEASE = 4;
`ifdef ADSR_GATE_SYNC_EN
  localparam int SYNC     = 1;
  localparam int GATE_LAT = 3;
`else
  localparam int SYNC     = 0;
  localparam int GATE_LAT = 1;
`endif
  // Counter phase at which a gate change lands its edge on a tick cycle.
  localparam int ALIGN = ((TICK_DIV - GATE_LAT) % TICK_DIV + TICK_DIV) % TICK_DIV;

  logic        clk;
  logic        reset;
  logic        gate;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] sustain_level;
  logic [15:0] release_step;
  logic [23:0] sample_in;
  logic [23:0] sample_out;
  logic [15:0] level;
  logic [2:0]  state;
  logic        active;

  adsr_envelope #(
    .SAMPLE_W(24),
    .LEVEL_W (16),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .level        (level),
    .state        (state),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sus;
    logic [23:0] smp;
    logic [23:0] exp;
  } scale_vec_t;

  scale_vec_t vt[8];

  int          n_checks;
  int          n_errors;
  int          m_cnt;
  int          m_s1;
  int          m_s2;
  int          m_gprev;
  int          m_state;
  int          m_level;
  logic [23:0] m_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of the envelope as the rules describe it, evaluated on the current inputs.
  task automatic model_step();
    int     g_seen;
    bit     tick;
    bit     rise;
    bit     fall;
    int     a;
    int     d;
    int     s;
    int     r;
    int     n;
    longint p;
    if (reset) begin
      m_cnt = 0; m_s1 = 0; m_s2 = 0; m_gprev = 0;
      m_state = S_IDLE; m_level = 0; m_out = '0;
      return;
    end
    tick   = (m_cnt == TICK_DIV - 1);
    m_cnt  = (m_cnt + 1) % TICK_DIV;
    g_seen = (SYNC != 0) ? m_s2 : int'(gate);
    m_s2   = m_s1;
    m_s1   = int'(gate);
    rise   = (g_seen == 1) && (m_gprev == 0);
    fall   = (g_seen == 0) && (m_gprev == 1);
    m_gprev = g_seen;
    p      = longint'($signed(sample_in)) * longint'(m_level);
    m_out  = 24'(p >>> 16);
    a = int'(attack_step); d = int'(decay_step);
    s = int'(sustain_level); r = int'(release_step);
    if (rise) begin
      m_state = S_ATTACK;
    end else if (fall) begin
      if (m_state inside {S_ATTACK, S_DECAY, S_SUSTAIN}) m_state = S_RELEASE;
    end else if (tick) begin
      case (m_state)
        S_ATTACK: begin
          n = (a == 0) ? 65535 : ((m_level + a > 65535) ? 65535 : m_level + a);
          m_level = n;
          if (n == 65535) m_state = S_DECAY;
        end
        S_DECAY: begin
          n = (d == 0) ? s : ((m_level - d > s) ? m_level - d : s);
          m_level = n;
          if (n == s) m_state = S_SUSTAIN;
        end
        S_SUSTAIN: m_level = s;
        S_RELEASE: begin
          n = (r == 0) ? 0 : ((m_level - r > 0) ? m_level - r : 0);
          m_level = n;
          if (n == 0) m_state = S_IDLE;
        end
        default: m_level = 0;
      endcase
    end
  endtask

  task automatic cycle();
    logic [43:0] exp_v;
    logic [43:0] act_v;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_v = {m_out, 16'(m_level), 3'(m_state), (m_state != S_IDLE)};
    act_v = {sample_out, level, state, active};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL cycle t=%0t actual out=%h lvl=%h st=%0d act=%0b required out=%h lvl=%h st=%0d act=%0b",
               $time, sample_out, level, state, active, m_out, 16'(m_level), m_state,
               (m_state != S_IDLE));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_pulse(input string name, input logic gate_during);
    #2 reset = 1'b1;
    #1 chk(name, {sample_out, level, state, active}, 64'd0);
    model_step();
    gate = gate_during;
    run(2);
    reset = 1'b0;
  endtask

  task automatic wait_change(input string name);
    int prev;
    int k;
    prev = m_level;
    k = 0;
    while (m_level == prev && k < 3 * TICK_DIV) begin
      cycle();
      k++;
    end
    if (m_level == prev) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s no level step within %0d cycles", name, k);
    end
  endtask

  task automatic wait_state(input int target, input string name);
    int k;
    k = 0;
    while (m_state != target && k < 20 * TICK_DIV) begin
      cycle();
      k++;
    end
    if (m_state != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s state %0d not reached, at %0d", name, target, m_state);
    end
  endtask

  task automatic align_tick();
    for (int k = 0; k < TICK_DIV && m_cnt != ALIGN; k++) cycle();
  endtask

  function automatic logic [15:0] rnd_step();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 255));
      default: return 16'($urandom_range(256, 65535));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l_snap;
    vt[0] = '{16'hFFFF, 24'h7FFFFF, 24'h7FFF7F};
    vt[1] = '{16'hFFFF, 24'h800000, 24'h800080};
    vt[2] = '{16'h8000, 24'h400000, 24'h200000};
    vt[3] = '{16'h8000, 24'h800000, 24'hC00000};
    vt[4] = '{16'h8000, 24'hFFFFFF, 24'hFFFFFF};
    vt[5] = '{16'h4000, 24'h7FFFFF, 24'h1FFFFF};
    vt[6] = '{16'hFFFF, 24'h000001, 24'h000000};
    vt[7] = '{16'h0000, 24'h7FFFFF, 24'h000000};

    n_checks = 0; n_errors = 0;
    reset = 1'b0; gate = 1'b0;
    attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
    sample_in = '0;
    #1;
    reset_pulse("reset_init", 1'b0);
    run(2);

    // Reset mid-attack with gate held high.
    attack_step = 16'h1000; sample_in = 24'h123456;
    gate = 1'b1;
    run(GATE_LAT + 3 * TICK_DIV);
    reset_pulse("reset_mid_attack", 1'b0);
    run(3 * TICK_DIV);
    chk("post_reset_idle", {level, state, active}, 64'd0);

    // Attack / decay / sustain / release with the documented step values.
    attack_step = 16'h4000; decay_step = 16'h1000;
    sustain_level = 16'h8000; release_step = 16'h0000;
    gate = 1'b1;
    run(GATE_LAT);
    chk("attack_entry", {level, state}, {16'h0000, 3'd1});
    wait_change("att1"); chk("att_lvl1", level, 16'h4000);
    wait_change("att2"); chk("att_lvl2", level, 16'h8000);
    wait_change("att3"); chk("att_lvl3", level, 16'hC000);
    wait_change("att4"); chk("att_sat", {level, state}, {16'hFFFF, 3'd2});
    for (int i = 1; i <= 7; i++) begin
      wait_change("dec");
      chk("decay_lvl", level, 16'hFFFF - 16'(i * 16'h1000));
    end
    wait_change("dec8"); chk("sustain_entry", {level, state}, {16'h8000, 3'd3});
    sustain_level = 16'h6000;
    wait_change("sus_track"); chk("sustain_track", {level, state}, {16'h6000, 3'd3});
    gate = 1'b0;
    run(GATE_LAT);
    chk("release_entry", {level, state}, {16'h6000, 3'd4});
    wait_change("rel0"); chk("release_zero_step", {level, state, active}, 64'd0);

    // Instant attack/decay, then retrigger from 0x3000 during release.
    attack_step = 16'h0000; decay_step = 16'h0000;
    sustain_level = 16'h5000; release_step = 16'h1000;
    gate = 1'b1;
    run(GATE_LAT);
    wait_change("inst_att"); chk("instant_attack", {level, state}, {16'hFFFF, 3'd2});
    wait_change("inst_dec"); chk("instant_decay", {level, state}, {16'h5000, 3'd3});
    gate = 1'b0;
    run(GATE_LAT);
    wait_change("rel1");
    wait_change("rel2"); chk("release_3000", {level, state}, {16'h3000, 3'd4});
    gate = 1'b1;
    run(GATE_LAT);
    chk("retrigger", {level, state}, {16'h3000, 3'd1});
    attack_step = 16'h4000;
    wait_change("re_att"); chk("retrigger_step", {level, state}, {16'h7000, 3'd1});

    // Scaling table: hold a known level in SUSTAIN and push one sample per row.
    attack_step = 16'h0000; decay_step = 16'h0000;
    wait_state(S_SUSTAIN, "scale_setup");
    foreach (vt[i]) begin
      sustain_level = vt[i].sus;
      run(TICK_DIV + 1);
      sample_in = vt[i].smp;
      cycle();
      chk($sformatf("scale_%0d", i), {level, sample_out}, {vt[i].sus, vt[i].exp});
    end

    // Gate edge coinciding with a tick: edge wins and the level holds.
    sustain_level = 16'h2000; decay_step = 16'h0100; release_step = 16'h0100;
    gate = 1'b0;
    run(GATE_LAT + 1);
    gate = 1'b1;
    wait_state(S_DECAY, "edge_setup");
    align_tick();
    l_snap = m_level;
    gate = 1'b0;
    run(GATE_LAT);
    chk("fall_on_tick", {level, state}, {16'(l_snap), 3'd4});
    run(2 * TICK_DIV);
    align_tick();
    l_snap = m_level;
    gate = 1'b1;
    run(GATE_LAT);
    chk("rise_on_tick", {level, state}, {16'(l_snap), 3'd1});

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0:       attack_step   = rnd_step();
          1:       decay_step    = rnd_step();
          2:       sustain_level = 16'($urandom_range(0, 65535));
          default: release_step  = rnd_step();
        endcase
      end
      sample_in = 24'($urandom);
      if ($urandom_range(0, 1499) == 0) reset_pulse("rand_reset", gate);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
